// File: rtl/mvma_stream_host.sv
`default_nettype none
// ============================================================================
// Module   : mvma_stream_host
// Purpose  : Host-side streaming front end for an MVMA engine. A packet of
//            N*N + 2*N signed words (A row-major, then b, then x) is loaded
//            through a write port. On start, the packet is streamed out on a
//            valid/ready master port. N result words plus overflow flags are
//            then collected from a valid/ready slave port. The block also
//            reports the number of SEND/RECV cycles the transaction took.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            cfg_wr_en/addr/data - packet buffer write port (IDLE only)
//            start, busy, done   - transaction control and status
//            m_valid/ready/data  - outbound packet stream
//            s_valid/ready/data, s_overflow - inbound result stream
//            res_addr, res_data, res_overflow - combinational result read
//            ovf_any             - OR of all stored overflow flags
//            cycles              - SEND+RECV cycle count of last transaction
// Revision : 1.0 - initial release
// ============================================================================
module mvma_stream_host #(
  parameter int N  = 4,
  parameter int IW = 8,
  parameter int OW = 16,
  localparam int PKT = N*N + 2*N,
  localparam int AW  = $clog2(PKT),
  localparam int RAW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_wr_en,
  input  logic [AW-1:0]        cfg_addr,
  input  logic signed [IW-1:0] cfg_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [IW-1:0] m_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [OW-1:0] s_data,
  input  logic                 s_overflow,
  input  logic [RAW-1:0]       res_addr,
  output logic signed [OW-1:0] res_data,
  output logic                 res_overflow,
  output logic                 ovf_any,
  output logic [15:0]          cycles
);

  localparam logic [AW-1:0]  LAST_TX = AW'(PKT - 1);
  localparam logic [RAW-1:0] LAST_RX = RAW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          tx_idx_q, tx_idx_d;
  logic [RAW-1:0]         rx_idx_q, rx_idx_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            cycles_q;
  logic [15:0]            cnt_inc;
  logic                   clr_res;
  logic                   cap_res;
  logic                   latch_cycles;
  logic                   addr_ok;

  logic signed [IW-1:0]   pkt_q [PKT];
  logic signed [OW-1:0]   res_q [N];
  logic [N-1:0]           ovf_q;

  // Saturating increment so a long-stalled transaction reports FFFF, not a wrap.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign addr_ok = ({1'b0, cfg_addr} < (AW+1)'(PKT));

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    tx_idx_d     = tx_idx_q;
    rx_idx_d     = rx_idx_q;
    cnt_d        = cnt_q;
    clr_res      = 1'b0;
    cap_res      = 1'b0;
    latch_cycles = 1'b0;
    m_valid      = 1'b0;
    s_ready      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SEND;
          tx_idx_d = '0;
          rx_idx_d = '0;
          cnt_d    = '0;
          clr_res  = 1'b1;
        end
      end
      SEND: begin
        m_valid = 1'b1;
        busy    = 1'b1;
        cnt_d   = cnt_inc;
        if (m_ready) begin
          if (tx_idx_q == LAST_TX) begin
            tx_idx_d = '0;
            state_d  = RECV;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      RECV: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        cnt_d   = cnt_inc;
        if (s_valid) begin
          cap_res = 1'b1;
          if (rx_idx_q == LAST_RX) begin
            rx_idx_d     = '0;
            state_d      = DONE;
            latch_cycles = 1'b1;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tx_idx_q <= '0;
      rx_idx_q <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      tx_idx_q <= tx_idx_d;
      rx_idx_q <= rx_idx_d;
      cnt_q    <= cnt_d;
      // cnt_inc already includes the final RECV cycle.
      if (latch_cycles) begin
        cycles_q <= cnt_inc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Packet buffer: not reset, so a reset abort can retransmit the same packet.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && (state_q == IDLE) && cfg_wr_en && addr_ok) begin
      pkt_q[cfg_addr] <= cfg_data;
    end
  end

  // --------------------------------------------------------------------------
  // Result storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || clr_res) begin
      for (int i = 0; i < N; i++) begin
        res_q[i] <= '0;
      end
      ovf_q <= '0;
    end else if (cap_res) begin
      res_q[rx_idx_q] <= s_data;
      ovf_q[rx_idx_q] <= s_overflow;
    end
  end

  assign m_data       = pkt_q[tx_idx_q];
  assign res_data     = res_q[res_addr];
  assign res_overflow = ovf_q[res_addr];
  assign ovf_any      = |ovf_q;
  assign cycles       = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_mvma_stream_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvma_stream_host
// Purpose  : Scoreboard bench for mvma_stream_host. Stimulus drives packets
//            and result beats and queues expected outbound words and result
//            readbacks; a negedge monitor compares DUT outputs against them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mvma_stream_host;

  localparam int N   = 4;
  localparam int IW  = 8;
  localparam int OW  = 16;
  localparam int PKT = N*N + 2*N;
  localparam int AW  = 5;
  localparam int RAW = 2;

  localparam int PH_IDLE = 0;
  localparam int PH_SEND = 1;
  localparam int PH_RECV = 2;
  localparam int PH_DONE = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_wr_en;
  logic [AW-1:0]  cfg_addr;
  logic [IW-1:0]  cfg_data;
  logic           start;
  logic           busy;
  logic           done;
  logic           m_valid;
  logic           m_ready;
  logic [IW-1:0]  m_data;
  logic           s_valid;
  logic           s_ready;
  logic [OW-1:0]  s_data;
  logic           s_overflow;
  logic [RAW-1:0] res_addr;
  logic [OW-1:0]  res_data;
  logic           res_overflow;
  logic           ovf_any;
  logic [15:0]    cycles;

  always #5 clk = ~clk;

  mvma_stream_host #(.N(N), .IW(IW), .OW(OW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_overflow   (s_overflow),
    .res_addr     (res_addr),
    .res_data     (res_data),
    .res_overflow (res_overflow),
    .ovf_any      (ovf_any),
    .cycles       (cycles)
  );

  // Reference model state
  int            phase;
  logic          rd_vld;
  logic [IW-1:0] pkt_ref [PKT];
  logic [OW-1:0] res_ref [N];
  logic [N-1:0]  ovf_ref;
  logic [15:0]   cycles_ref;
  logic [OW-1:0] dir_s [4] = '{16'd51, 16'd124, 16'd197, 16'd270};

  // Scoreboard queues
  logic [IW-1:0] exp_m [$];
  logic [OW-1:0] exp_rd_d [$];
  logic          exp_rd_o [$];

  int nchk  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("m_valid", 32'(m_valid), 32'(phase == PH_SEND));
      chk("s_ready", 32'(s_ready), 32'(phase == PH_RECV));
      chk("busy",    32'(busy),    32'(phase == PH_SEND || phase == PH_RECV));
      chk("done",    32'(done),    32'(phase == PH_DONE));
      if (m_valid && phase == PH_SEND) begin
        if (exp_m.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL m_beat: got unexpected beat %0h expected none at %0t", m_data, $time);
        end else begin
          chk("m_data", 32'(m_data), 32'(exp_m[0]));
          if (m_ready) void'(exp_m.pop_front());
        end
      end
      if (phase == PH_DONE || phase == PH_IDLE) begin
        chk("cycles",  32'(cycles),  32'(cycles_ref));
        chk("ovf_any", 32'(ovf_any), 32'(|ovf_ref));
      end
      if (rd_vld) begin
        if (exp_rd_d.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL res_read: got readback expected none at %0t", $time);
        end else begin
          chk("res_data",     32'(res_data),     32'(exp_rd_d.pop_front()));
          chk("res_overflow", 32'(res_overflow), 32'(exp_rd_o.pop_front()));
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    cfg_wr_en  = 1'b0;
    start      = 1'b0;
    m_ready    = 1'b0;
    s_valid    = 1'b0;
    s_overflow = 1'b0;
    rd_vld     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    quiet();
    exp_m.delete();
    tick();
    tick();
    reset      = 1'b0;
    phase      = PH_IDLE;
    cycles_ref = '0;
    ovf_ref    = '0;
    for (int i = 0; i < N; i++) res_ref[i] = '0;
  endtask

  task automatic write_word(input int a, input logic [IW-1:0] d);
    cfg_wr_en  = 1'b1;
    cfg_addr   = AW'(a);
    cfg_data   = d;
    pkt_ref[a] = d;
    tick();
    cfg_wr_en  = 1'b0;
  endtask

  task automatic readback();
    phase = PH_IDLE;
    for (int i = 0; i < N; i++) begin
      res_addr = RAW'(i);
      rd_vld   = 1'b1;
      exp_rd_d.push_back(res_ref[i]);
      exp_rd_o.push_back(ovf_ref[i]);
      tick();
    end
    rd_vld = 1'b0;
  endtask

  // mode_m: 0 = m_ready always 1, 1 = random, 2 = 3-cycle stall at word index 5
  // mode_s: 0 = directed results with overflow on beat 2, 1 = random
  task automatic run_txn(input int mode_m, input int mode_s, input bit noise,
                         input bit wr_with_start, input int abort_at);
    int sent;
    int got;
    int ncyc;
    int stall;
    int a;
    sent  = 0;
    got   = 0;
    ncyc  = 0;
    stall = 0;

    start = 1'b1;
    if (wr_with_start) begin
      a = $urandom_range(0, PKT-1);
      cfg_wr_en  = 1'b1;
      cfg_addr   = AW'(a);
      cfg_data   = IW'($urandom);
      pkt_ref[a] = cfg_data;
    end
    foreach (pkt_ref[i]) exp_m.push_back(pkt_ref[i]);
    tick();
    start     = 1'b0;
    cfg_wr_en = 1'b0;
    phase     = PH_SEND;
    ovf_ref   = '0;
    for (int i = 0; i < N; i++) res_ref[i] = '0;

    while (sent < PKT) begin
      if (abort_at >= 0 && sent == abort_at) begin
        do_reset();
        return;
      end
      case (mode_m)
        0: m_ready = 1'b1;
        1: m_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (sent == 5 && stall < 3) begin
            m_ready = 1'b0;
            stall++;
          end else begin
            m_ready = 1'b1;
          end
        end
      endcase
      if (noise) begin
        start      = 1'($urandom);
        cfg_wr_en  = 1'($urandom);
        cfg_addr   = AW'($urandom_range(0, PKT-1));
        cfg_data   = IW'($urandom);
        s_valid    = 1'($urandom);
        s_data     = OW'($urandom);
        s_overflow = 1'($urandom);
      end
      ncyc++;
      if (m_ready) sent++;
      tick();
    end

    m_ready   = 1'b0;
    start     = 1'b0;
    cfg_wr_en = 1'b0;
    phase     = PH_RECV;
    while (got < N) begin
      if (mode_s == 0) begin
        s_valid    = 1'b1;
        s_data     = dir_s[got];
        s_overflow = (got == 2);
      end else begin
        s_valid    = ($urandom_range(0, 2) != 0);
        s_data     = OW'($urandom);
        s_overflow = 1'($urandom);
      end
      if (noise) begin
        start     = 1'($urandom);
        cfg_wr_en = 1'($urandom);
        cfg_addr  = AW'($urandom_range(0, PKT-1));
        cfg_data  = IW'($urandom);
      end
      if (s_valid) begin
        res_ref[got] = s_data;
        ovf_ref[got] = s_overflow;
        got++;
      end
      ncyc++;
      tick();
    end

    phase      = PH_DONE;
    cycles_ref = (ncyc > 65535) ? 16'hFFFF : 16'(ncyc);
    start      = noise ? 1'($urandom) : 1'b0;
    cfg_wr_en  = noise ? 1'($urandom) : 1'b0;
    s_valid    = noise ? 1'($urandom) : 1'b0;
    s_data     = OW'($urandom);
    tick();
    quiet();
    readback();
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    reset      = 1'b1;
    phase      = PH_IDLE;
    quiet();
    res_addr   = '0;
    cfg_addr   = '0;
    cfg_data   = '0;
    s_data     = '0;
    cycles_ref = '0;
    ovf_ref    = '0;
    for (int i = 0; i < PKT; i++) pkt_ref[i] = '0;

    // Reset state: results and flags read back as zero.
    do_reset();
    readback();

    // Directed packet: A = 1..16, b = 1..4, x = 3..6.
    for (int i = 0; i < 16; i++) write_word(i, IW'(i + 1));
    for (int i = 0; i < 4; i++)  write_word(16 + i, IW'(i + 1));
    for (int i = 0; i < 4; i++)  write_word(20 + i, IW'(i + 3));

    // Back-to-back stream, directed results, overflow on beat 2 only.
    run_txn(0, 0, 1'b0, 1'b0, -1);
    chk("cycles_min_latency", 32'(cycles), 32'd28);

    // Three-cycle m_ready stall at word index 5.
    run_txn(2, 0, 1'b0, 1'b0, -1);
    chk("cycles_with_stall", 32'(cycles), 32'd31);

    // Reset after 10 beats, then restart: stream starts over from word 0.
    run_txn(0, 1, 1'b1, 1'b0, 10);
    readback();
    run_txn(0, 0, 1'b0, 1'b0, -1);

    // Randomized transactions with noise on ignored inputs.
    for (int t = 0; t < 8; t++) begin
      for (int w = 0; w < 3; w++) begin
        write_word($urandom_range(0, PKT-1), IW'($urandom));
      end
      run_txn(1, 1, 1'b1, 1'b1, -1);
    end

    tick();
    chk("m_queue_drained",  32'(exp_m.size()),    32'd0);
    chk("rd_queue_drained", 32'(exp_rd_d.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
`default_nettype wire
